// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and control-vector constants for the pipeline
//            hazard controller (forwarding selects, timer states, en/bubble
//            bundle).
// Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    T_IDLE = 1'b0,
    T_WAIT = 1'b1
  } timer_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_bubble;
    logic memwb_bubble;
  } hazard_ctrl_t;

  // One control vector per pipeline situation, highest priority first
  localparam hazard_ctrl_t HC_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
    ifid_flush: 1'b0, idex_bubble: 1'b1, exmem_bubble: 1'b1, memwb_bubble: 1'b1};
  localparam hazard_ctrl_t HC_MEM_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
    ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b0, memwb_bubble: 1'b1};
  localparam hazard_ctrl_t HC_EX_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b1,
    ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b1, memwb_bubble: 1'b0};
  localparam hazard_ctrl_t HC_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
    ifid_flush: 1'b1, idex_bubble: 1'b1, exmem_bubble: 1'b0, memwb_bubble: 1'b0};
  localparam hazard_ctrl_t HC_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1,
    ifid_flush: 1'b0, idex_bubble: 1'b1, exmem_bubble: 1'b0, memwb_bubble: 1'b0};
  localparam hazard_ctrl_t HC_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
    ifid_flush: 1'b0, idex_bubble: 1'b0, exmem_bubble: 1'b0, memwb_bubble: 1'b0};

  // MEM result is younger than WB, so it wins when both match
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Pipeline-side view of the hazard controller: stage register
//            tags in, stage enables / bubbles / forwarding selects out.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int RF_ADDRESS = 5
);
  logic [RF_ADDRESS-1:0] id_rs1, id_rs2;
  logic                  id_use_rs1, id_use_rs2;
  logic [RF_ADDRESS-1:0] ex_rs1, ex_rs2, ex_rd;
  logic                  ex_memread, ex_multicycle, br_taken;
  logic [RF_ADDRESS-1:0] mem_rd;
  logic                  mem_regwrite, mem_memread;
  logic [RF_ADDRESS-1:0] wb_rd;
  logic                  wb_regwrite;

  logic                  pc_en, ifid_en, idex_en, exmem_en;
  logic                  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;
  logic [1:0]            fwd_a, fwd_b;
  logic                  ex_last;
  logic [31:0]           stall_cycles, flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_memread, ex_multicycle, br_taken, mem_rd, mem_regwrite,
           mem_memread, wb_rd, wb_regwrite,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
           exmem_bubble, memwb_bubble, fwd_a, fwd_b, ex_last,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_memread, ex_multicycle, br_taken, mem_rd, mem_regwrite,
           mem_memread, wb_rd, wb_regwrite,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
           exmem_bubble, memwb_bubble, fwd_a, fwd_b, ex_last,
           stall_cycles, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_stall_timer.sv
`default_nettype none
// ============================================================================
// Module   : stall_timer
// Brief    : Multi-cycle stall timer. Raises busy on the start cycle and for
//            load-1 further cycles; last marks the release cycle. Freeze
//            holds the state and count untouched.
// Revision : 1.0  initial release
// ============================================================================
module stall_timer
  import hazard_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             freeze_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             busy_o,
  output logic             last_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  timer_state_e     state_q;
  logic [CNT_W-1:0] count_q;

  // Arm on start, count down while waiting, release when the count hits one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= T_IDLE;
      count_q <= '0;
    end else if (!freeze_i) begin
      case (state_q)
        T_IDLE: begin
          if (start_i) begin
            state_q <= T_WAIT;
            count_q <= load_i;
          end
        end
        T_WAIT: begin
          if (count_q > ONE) begin
            count_q <= count_q - ONE;
          end else begin
            state_q <= T_IDLE;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= T_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  // Stall is visible in the very cycle the operation is first seen
  assign busy_o = (state_q == T_IDLE) ? start_i : (count_q > ONE);
  assign last_o = (state_q == T_WAIT) && (count_q == ONE);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Central hazard controller for the 5-stage pipeline: operand
//            forwarding, multi-cycle MEM/EX stalls, load-use interlock and
//            branch redirect. Optional perf counters under PIPE_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int MUL_LAT    = 4,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
);
  localparam logic [RF_ADDRESS-1:0] X0        = '0;
  localparam logic [CNT_W-1:0]      MEM_LOAD  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]      MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam bit                    MEM_MULTI = (MEM_LAT > 1);
  localparam bit                    MUL_MULTI = (MUL_LAT > 1);

  logic         mem_stall, mem_last_unused;
  logic         ex_busy, ex_timer_last;
  logic         load_use;
  logic         mem_fwd_ok, wb_fwd_ok;
  fwd_sel_e     fwd_a, fwd_b;
  hazard_ctrl_t hc;

  stall_timer #(.CNT_W(CNT_W)) u_mem_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (bus.mem_memread & MEM_MULTI),
    .freeze_i (1'b0),
    .load_i   (MEM_LOAD),
    .busy_o   (mem_stall),
    .last_o   (mem_last_unused)
  );

  // EX timer stands still while a memory stall holds the whole pipe
  stall_timer #(.CNT_W(CNT_W)) u_ex_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (bus.ex_multicycle & MUL_MULTI),
    .freeze_i (mem_stall),
    .load_i   (MUL_LOAD),
    .busy_o   (ex_busy),
    .last_o   (ex_timer_last)
  );

  assign mem_fwd_ok = bus.mem_regwrite & (bus.mem_rd != X0);
  assign wb_fwd_ok  = bus.wb_regwrite  & (bus.wb_rd  != X0);
  assign fwd_a = fwd_select(mem_fwd_ok & (bus.mem_rd == bus.ex_rs1),
                            wb_fwd_ok  & (bus.wb_rd  == bus.ex_rs1));
  assign fwd_b = fwd_select(mem_fwd_ok & (bus.mem_rd == bus.ex_rs2),
                            wb_fwd_ok  & (bus.wb_rd  == bus.ex_rs2));

  assign load_use = bus.ex_memread & (bus.ex_rd != X0) &
                    ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Pick the stage control vector by priority: reset, mem, ex, branch, load-use
  always_comb begin
    hc = HC_NORMAL;
    if (!reset)            hc = HC_RESET;
    else if (mem_stall)    hc = HC_MEM_STALL;
    else if (ex_busy)      hc = HC_EX_STALL;
    else if (bus.br_taken) hc = HC_BRANCH;
    else if (load_use)     hc = HC_LOAD_USE;
  end

  assign bus.pc_en        = hc.pc_en;
  assign bus.ifid_en      = hc.ifid_en;
  assign bus.idex_en      = hc.idex_en;
  assign bus.exmem_en     = hc.exmem_en;
  assign bus.ifid_flush   = hc.ifid_flush;
  assign bus.idex_bubble  = hc.idex_bubble;
  assign bus.exmem_bubble = hc.exmem_bubble;
  assign bus.memwb_bubble = hc.memwb_bubble;
  assign bus.fwd_a        = reset ? fwd_a : FWD_RF;
  assign bus.fwd_b        = reset ? fwd_b : FWD_RF;
  // Result cycle: final count of a multi-cycle op, or any cycle EX is not held
  assign bus.ex_last      = reset & (ex_timer_last | ~ex_busy);

`ifdef PIPE_PERF_CNT_EN
  logic        br_honoured;
  logic [31:0] stall_cycles_q, flush_count_q;

  assign br_honoured = reset & ~mem_stall & ~ex_busy & bus.br_taken;

  // Count frozen-PC cycles and honoured redirects, wrapping at 2**32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!hc.pc_en) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (br_honoured) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised, parametrised hazard controller for the 5-stage RISC-V pipeline.
- Replaces the split hazard-detection and forwarding blocks.
- Adds multi-cycle EX operations (MUL_LAT), multi-cycle data-memory reads (MEM_LAT), and a branch redirect that is held while the pipe is frozen.
- Drives every stage-register enable/bubble, the PC enable and both forwarding mux selects.

Parameters:
- RF_ADDRESS, 5, register-file address width.
- MUL_LAT, 4, total EX cycles of a multi-cycle op (>=1; 1 = no stall).
- MEM_LAT, 1, total MEM cycles of a load (>=1; 1 = no stall).
- CNT_W, 4, width of internal stall timers; must satisfy 2**CNT_W > max(MUL_LAT, MEM_LAT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- id_rs1, id_rs2  in  RF_ADDRESS  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  RF_ADDRESS  source registers in EX.
- ex_rd  in  RF_ADDRESS  destination register in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_multicycle  in  1  EX instruction is a multi-cycle op.
- br_taken  in  1  EX branch/jump redirect.
- mem_rd  in  RF_ADDRESS  destination register in MEM.
- mem_regwrite  in  1  MEM instruction writes the register file.
- mem_memread  in  1  MEM instruction is a load.
- wb_rd  in  RF_ADDRESS  destination register in WB.
- wb_regwrite  in  1  WB instruction writes the register file.
- pc_en  out  1  PC register load enable.
- ifid_en, idex_en, exmem_en  out  1  stage-register hold (0 = hold).
- ifid_flush  out  1  clear IF/ID.
- idex_bubble, exmem_bubble, memwb_bubble  out  1  load a NOP into the next stage.
- fwd_a, fwd_b  out  2  EX operand select (00 RF, 01 WB, 10 MEM).
- ex_last  out  1  current EX cycle is the result cycle of the EX op.
- stall_cycles  out  32  perf counter (optional feature).
- flush_count  out  32  perf counter (optional feature).

Behaviour:
- Reset (reset=0, async): both timers idle, counters 0. Outputs while in reset:
  - all *_en=0, ifid_flush=0, all bubbles=1;
  - fwd_a=fwd_b=00, ex_last=0.
- Forwarding (combinational):
  - fwd_a=10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1;
  - else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00. fwd_b is identical using ex_rs2. MEM beats WB.
- Memory timer (M_IDLE/M_WAIT):
  - M_IDLE & mem_memread & MEM_LAT>1: mem_stall=1, load count=MEM_LAT-1, go M_WAIT.
  - M_WAIT: mem_stall=1 while count>1, decrementing. At count==1: mem_stall=0, return M_IDLE.
  - Load stall = MEM_LAT-1 cycles; back-to-back loads each stall.
  - mem_stall: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1.
- EX timer (E_IDLE/E_WAIT):
  - E_IDLE & ex_multicycle & MUL_LAT>1: ex_stall=1, load count=MUL_LAT-1, go E_WAIT.
  - E_WAIT: ex_stall while count>1, decrementing. At count==1: ex_last=1, return E_IDLE.
  - When MUL_LAT==1 or the op is not multi-cycle, ex_last=1 every non-stalled cycle.
  - The EX count freezes (no decrement, no transition) while mem_stall=1.
  - ex_stall (no mem_stall): pc_en=ifid_en=idex_en=0, exmem_bubble=1.
- Load-use (no mem_stall, no ex_stall):
  - Trigger: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_en=ifid_en=0, idex_bubble=1 for exactly one cycle.
- Branch:
  - br_taken is honoured only when mem_stall=0 and ex_stall=0. Response: ifid_flush=1, idex_bubble=1, pc_en=1.
  - Branch beats load-use in the same cycle.
  - br_taken arriving under a stall has no effect until the stall clears; EX is frozen, so br_taken persists.
- Priority: mem_stall > ex_stall > branch > load-use > normal.
- Normal: all en=1, all bubbles=0, ifid_flush=0.
- Reset mid-stall: timers return to idle immediately; no residual stall after release.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle pc_en=0 while out of reset;
  - flush_count increments on each honoured br_taken;
  - both counters wrap at 2**32 and clear on reset.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - timer_state_e (T_IDLE, T_WAIT);
  - hazard_ctrl_t struct bundling the en/bubble/flush outputs.
- Sub-module stall_timer, instantiated twice (memory, EX):
  - inputs: start, freeze, load value;
  - outputs: busy, last.

Test Plan:
- MEM_LAT=3, load x5 reaches MEM, no other hazards -> exmem_en=0 and memwb_bubble=1 for exactly 2 cycles, then all en=1.
- MUL_LAT=4, mul x6 in EX -> idex_en=0 and exmem_bubble=1 for 3 cycles; ex_last=1 on the 4th cycle.
- Load x7 in EX, ID add x8,x7,x1 -> one cycle pc_en=0, idex_bubble=1; next cycle fwd_a=10 is not used (load now in MEM), fwd_a=01 one cycle later.
- mem_rd=wb_rd=x9, both regwrite, ex_rs1=ex_rs2=x9 -> fwd_a=fwd_b=10. With rd=x0 -> 00.
- br_taken=1 during a 3-cycle MEM_LAT stall -> no flush until release; on the release cycle ifid_flush=1, idex_bubble=1; flush_count +1 with PIPE_PERF_CNT_EN.
- reset=0 asserted mid E_WAIT (count=2) -> outputs go to reset values asynchronously; after reset=1 with ex_multicycle=0, all en=1 on the first edge.
